// File: rtl/seq_rec_scheduler_if.sv
// Requester-side bus of the shared sequence-recognizer scheduler:
// word requests in, per-word grant and result out.
interface seq_rec_scheduler_if #(
   parameter int N_REQ = 2,
   parameter int W     = 8,
   parameter int CW    = $clog2(W + 1),
   parameter int IDW   = $clog2(N_REQ)
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] data;
   logic [N_REQ-1:0]   ack;
   logic               done;
   logic [IDW-1:0]     done_id;
   logic [CW-1:0]      match_cnt;

   modport master (
      output req,
      output data,
      input  ack,
      input  done,
      input  done_id,
      input  match_cnt
   );

   modport slave (
      input  req,
      input  data,
      output ack,
      output done,
      output done_id,
      output match_cnt
   );
endinterface

// File: rtl/seq_rec_scheduler.sv
// Round-robin scheduler feeding requester words, LSB first, into one
// shared serial "three-1s" recognizer and counting its hits per word.
module seq_rec_scheduler #(
   parameter  int N_REQ = 2,
   parameter  int W     = 8,
   parameter  int MOORE = 0,
   localparam int CW    = $clog2(W + 1),
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                reset,
   seq_rec_scheduler_if.slave  bus,
   output logic                busy,
   output logic                rec_din,
   output logic                rec_en,
   output logic                rec_clr,
   input  logic                rec_dout
);

   localparam int BIW = $clog2(W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_cur_id;
   logic [W-1:0]     r_shreg;
   logic [CW-1:0]    r_cnt;
   logic [BIW-1:0]   r_bit_idx;
   logic [IDW-1:0]   r_done_id;
   logic [CW-1:0]    r_match_cnt;

   logic             w_any;
   logic [IDW-1:0]   w_sel;
   logic             w_hit;
   logic [CW-1:0]    w_cnt_nxt;

   // Round-robin pick: first requester after the last granted one.
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!w_any && bus.req[(int'(r_ptr) + k) % N_REQ]) begin
            w_any = 1'b1;
            w_sel = IDW'((int'(r_ptr) + k) % N_REQ);
         end
      end
   end

   // Hit qualification; Moore output lags the shift by one cycle.
   always_comb begin
      w_hit = 1'b0;
      if (r_state == S_SHIFT)
         w_hit = rec_dout && ((MOORE == 0) || (r_bit_idx != '0));
      else if (r_state == S_DRAIN)
         w_hit = rec_dout;
      w_cnt_nxt = r_cnt + CW'(w_hit);
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = S_CLEAR;
         S_CLEAR: w_state_nxt = S_SHIFT;
         S_SHIFT: begin
            if (r_bit_idx == BIW'(W - 1))
               w_state_nxt = (MOORE != 0) ? S_DRAIN : S_DONE;
         end
         S_DRAIN: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register, updated with the recognizer on the falling edge.
   always_ff @(negedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Word latch, serializer, hit counter and result registers.
   always_ff @(negedge clk) begin
      if (reset) begin
         r_ptr       <= IDW'(N_REQ - 1);
         r_cur_id    <= '0;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_done_id   <= '0;
         r_match_cnt <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_shreg  <= bus.data[int'(w_sel) * W +: W];
                  r_cur_id <= w_sel;
                  r_ptr    <= w_sel;
               end
            end
            S_CLEAR: begin
               r_cnt     <= '0;
               r_bit_idx <= '0;
            end
            S_SHIFT: begin
               r_shreg   <= r_shreg >> 1;
               r_bit_idx <= r_bit_idx + 1'b1;
               r_cnt     <= w_cnt_nxt;
            end
            S_DRAIN: r_cnt <= w_cnt_nxt;
            default: ;
         endcase
         if (w_state_nxt == S_DONE) begin
            r_done_id   <= r_cur_id;
            r_match_cnt <= w_cnt_nxt;
         end
      end
   end

   // Outputs; reset forces every strobe idle and clears the recognizer.
   always_comb begin
      busy    = !reset && (r_state != S_IDLE);
      rec_en  = !reset && (r_state == S_SHIFT);
      rec_din = rec_en && r_shreg[0];
      rec_clr = reset || (r_state == S_CLEAR);
      bus.ack = '0;
      if (!reset && (r_state == S_CLEAR))
         bus.ack = N_REQ'(1) << r_cur_id;
      bus.done      = !reset && (r_state == S_DONE);
      bus.done_id   = r_done_id;
      bus.match_cnt = r_match_cnt;
   end

endmodule

// File: tb/tb_seq_rec_scheduler.sv
// Directed bench: a Mealy and a Moore scheduler instance, each driving
// its own behavioural three-1s recognizer.
module tb_seq_rec_scheduler;

   logic clk;
   logic rst0, rst1;

   logic [1:0]  req_t [2];
   logic [15:0] dat_t [2];
   logic [1:0]  ack_o [2];
   logic [3:0]  mc_o  [2];
   logic [1:0]  done_o, did_o, busy_o, din_o, en_o, clr_o, dout_i;

   int n_vec = 0;
   int n_err = 0;

   seq_rec_scheduler_if #(.N_REQ(2), .W(8)) bi0 ();
   seq_rec_scheduler_if #(.N_REQ(2), .W(8)) bi1 ();

   assign bi0.req  = req_t[0];
   assign bi0.data = dat_t[0];
   assign bi1.req  = req_t[1];
   assign bi1.data = dat_t[1];
   assign ack_o[0] = bi0.ack;
   assign ack_o[1] = bi1.ack;
   assign mc_o[0]  = bi0.match_cnt;
   assign mc_o[1]  = bi1.match_cnt;
   assign done_o   = {bi1.done, bi0.done};
   assign did_o    = {bi1.done_id, bi0.done_id};

   seq_rec_scheduler #(.N_REQ(2), .W(8), .MOORE(0)) u_mealy (
      .clk      (clk),
      .reset    (rst0),
      .bus      (bi0.slave),
      .busy     (busy_o[0]),
      .rec_din  (din_o[0]),
      .rec_en   (en_o[0]),
      .rec_clr  (clr_o[0]),
      .rec_dout (dout_i[0])
   );

   seq_rec_scheduler #(.N_REQ(2), .W(8), .MOORE(1)) u_moore (
      .clk      (clk),
      .reset    (rst1),
      .bus      (bi1.slave),
      .busy     (busy_o[1]),
      .rec_din  (din_o[1]),
      .rec_en   (en_o[1]),
      .rec_clr  (clr_o[1]),
      .rec_dout (dout_i[1])
   );

   // Mealy recognizer: hit when the current bit completes 1,1,1.
   logic [1:0] mh;
   always @(negedge clk)
      if (clr_o[0]) mh <= 2'b00;
      else if (en_o[0]) mh <= {mh[0], din_o[0]};
   assign dout_i[0] = en_o[0] & din_o[0] & (mh == 2'b11);

   // Moore recognizer: registered window of the last three bits.
   logic [2:0] ms;
   always @(negedge clk)
      if (clr_o[1]) ms <= 3'b000;
      else if (en_o[1]) ms <= {ms[1:0], din_o[1]};
   assign dout_i[1] = &ms;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One word through instance m from requester id, from an idle DUT.
   task automatic run_word(input int m, input int id,
                           input logic [7:0] d, input int exp_cnt);
      int lat;
      int nb;
      logic [7:0] ser;
      req_t[m][id] = 1'b1;
      dat_t[m][id*8 +: 8] = d;
      lat = 0;
      while (ack_o[m] == 2'b00 && lat < 20) begin
         @(posedge clk);
         lat++;
      end
      chk("ack_lat", lat, 1);
      chk("ack_onehot", int'(ack_o[m]), 1 << id);
      chk("clr_in_ack", int'(clr_o[m]), 1);
      req_t[m][id] = 1'b0;
      ser = 8'h00;
      nb = 0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         if (lat == 1) begin
            chk("ack_pulse", int'(ack_o[m]), 0);
            chk("busy_run", int'(busy_o[m]), 1);
         end
         if (en_o[m]) begin
            if (nb < 8) ser[nb] = din_o[m];
            nb++;
         end
      end while (!done_o[m] && lat < 30);
      chk("done_lat", lat, 9 + m);
      chk("serial", int'(ser), int'(d));
      chk("nbits", nb, 8);
      chk("done_id", int'(did_o[m]), id);
      chk("match_cnt", int'(mc_o[m]), exp_cnt);
      @(posedge clk);
      chk("done_pulse", int'(done_o[m]), 0);
      chk("busy_idle", int'(busy_o[m]), 0);
      chk("match_hold", int'(mc_o[m]), exp_cnt);
   endtask

   int lat;
   int exp_id [4] = '{0, 1, 0, 1};
   int exp_mc [4] = '{1, 6, 1, 4};
   int ndone;

   initial begin
      rst0 = 1'b1;
      rst1 = 1'b1;
      req_t[0] = 2'b00;
      req_t[1] = 2'b00;
      dat_t[0] = 16'h0000;
      dat_t[1] = 16'h0000;
      repeat (3) @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("rst_ack", int'(ack_o[m]), 0);
         chk("rst_busy", int'(busy_o[m]), 0);
         chk("rst_done", int'(done_o[m]), 0);
         chk("rst_done_id", int'(did_o[m]), 0);
         chk("rst_match", int'(mc_o[m]), 0);
         chk("rst_en", int'(en_o[m]), 0);
         chk("rst_din", int'(din_o[m]), 0);
         chk("rst_clr", int'(clr_o[m]), 1);
      end
      rst0 = 1'b0;
      rst1 = 1'b0;
      repeat (2) @(posedge clk);
      chk("idle_clr", int'(clr_o[0]), 0);

      run_word(0, 0, 8'h07, 1);
      run_word(0, 0, 8'hFF, 6);
      run_word(1, 0, 8'hFF, 6);
      run_word(1, 1, 8'hE0, 1);
      run_word(0, 0, 8'hC0, 0);
      run_word(0, 0, 8'h01, 0);

      // Abort a word with reset in its 4th shift cycle.
      req_t[0][0] = 1'b1;
      dat_t[0][7:0] = 8'hFF;
      lat = 0;
      while (ack_o[0] == 2'b00 && lat < 20) begin
         @(posedge clk);
         lat++;
      end
      chk("abort_ack", int'(ack_o[0]), 1);
      req_t[0][0] = 1'b0;
      repeat (4) @(posedge clk);
      chk("abort_shift", int'(en_o[0]), 1);
      rst0 = 1'b1;
      #1;
      chk("abort_busy", int'(busy_o[0]), 0);
      chk("abort_clr", int'(clr_o[0]), 1);
      chk("abort_en", int'(en_o[0]), 0);
      @(posedge clk);
      rst0 = 1'b0;
      chk("abort_idle", int'(busy_o[0]), 0);
      ndone = 0;
      repeat (15) begin
         @(posedge clk);
         if (done_o[0]) ndone++;
      end
      chk("abort_nodone", ndone, 0);
      run_word(0, 1, 8'h07, 1);

      // Both requesters held high: grants alternate.
      req_t[0] = 2'b11;
      dat_t[0] = {8'hFF, 8'h07};
      for (int g = 0; g < 4; g++) begin
         lat = 0;
         do begin
            @(posedge clk);
            lat++;
         end while (ack_o[0] == 2'b00 && lat < 40);
         chk("rr_ack", int'(ack_o[0]), 1 << exp_id[g]);
         case (g)
            0: dat_t[0][7:0]  = 8'h0E;
            1: dat_t[0][15:8] = 8'h3F;
            2: dat_t[0][7:0]  = 8'h00;
            default: req_t[0] = 2'b00;
         endcase
         lat = 0;
         do begin
            @(posedge clk);
            lat++;
         end while (!done_o[0] && lat < 40);
         chk("rr_done_lat", lat, 9);
         chk("rr_done_id", int'(did_o[0]), exp_id[g]);
         chk("rr_match", int'(mc_o[0]), exp_mc[g]);
      end
      repeat (3) @(posedge clk);
      chk("rr_end_busy", int'(busy_o[0]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
